condicionador_botoes: RTL and testbench

- Upstream input stage that conditions the 9 raw board push-buttons before they reach the game datapath's `botoes` bus.
- Synchronises and debounces the buttons, and rejects multi-button presses and presses made while play is disabled.
- Presents a clean, held one-hot code plus a one-cycle `jogada` pulse, so the datapath's XOR/edge-detect sees exactly one transition per accepted press.

---
 rtl/condicionador_botoes.sv | 131 +++++++++++++
 tb/tb_condicionador_botoes.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// Button conditioner: 2-FF sync, debounce, one-hot/enable filter, one-cycle jogada pulse.
// Optional jogada counter output enabled by `define CONDICIONADOR_CONTADOR_EN.
module condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 1000,
  parameter int CW              = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes_in,
  input  logic       habilita,
  output logic [8:0] botoes_out,
  output logic       jogada,
  output logic       multiplo,
  output logic [2:0] db_estado
`ifdef CONDICIONADOR_CONTADOR_EN
  ,
  output logic [6:0] db_num_jogadas
`endif
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    ACEITO        = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    ERRO          = 3'd4
  } estado_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  estado_t       estado, estado_nx;
  logic [8:0]    s1, s2;
  logic [8:0]    cap, cap_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [8:0]    bout_nx;
  logic          um_so;

  assign um_so = (cap != 9'd0) && ((cap & (cap - 9'd1)) == 9'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      cap        <= '0;
      cnt        <= '0;
      botoes_out <= '0;
      estado     <= OCIOSO;
    end else begin
      s1         <= botoes_in;
      s2         <= s1;
      cap        <= cap_nx;
      cnt        <= cnt_nx;
      botoes_out <= bout_nx;
      estado     <= estado_nx;
    end
  end

  always_comb begin
    estado_nx = estado;
    cap_nx    = cap;
    cnt_nx    = cnt;
    bout_nx   = botoes_out;
    case (estado)
      OCIOSO: begin
        if (s2 != 9'd0) begin
          cap_nx    = s2;
          cnt_nx    = '0;
          estado_nx = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s2 == 9'd0) begin
          estado_nx = OCIOSO;
        end else if (s2 != cap) begin
          cap_nx = s2;
          cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
          // Stable press: release filter starts fresh in every exit state
          cnt_nx = '0;
          if (!um_so) begin
            estado_nx = ERRO;
          end else if (habilita) begin
            estado_nx = ACEITO;
            bout_nx   = cap;
          end else begin
            estado_nx = ESPERA_SOLTAR;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ACEITO: begin
        estado_nx = ESPERA_SOLTAR;
        cnt_nx    = '0;
      end
      ESPERA_SOLTAR, ERRO: begin
        if (s2 == 9'd0) begin
          if (cnt == CNT_MAX) begin
            estado_nx = OCIOSO;
            bout_nx   = '0;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          cnt_nx = '0;
        end
      end
      default: begin
        estado_nx = OCIOSO;
        bout_nx   = '0;
        cnt_nx    = '0;
      end
    endcase
  end

  assign jogada    = (estado == ACEITO);
  assign multiplo  = (estado == ERRO);
  assign db_estado = estado;

`ifdef CONDICIONADOR_CONTADOR_EN
  // Saturates at a full 9x9 board
  always_ff @(posedge clock) begin
    if (reset)
      db_num_jogadas <= '0;
    else if (jogada && db_num_jogadas != 7'd81)
      db_num_jogadas <= db_num_jogadas + 7'd1;
  end
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes with DEBOUNCE_CICLOS=4.
module tb_condicionador_botoes;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] botoes_in;
  logic       habilita;
  logic [8:0] botoes_out;
  logic       jogada;
  logic       multiplo;
  logic [2:0] db_estado;
`ifdef CONDICIONADOR_CONTADOR_EN
  logic [6:0] db_num_jogadas;
`endif

  condicionador_botoes #(.DEBOUNCE_CICLOS(D), .CW(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes_in  (botoes_in),
    .habilita   (habilita),
    .botoes_out (botoes_out),
    .jogada     (jogada),
    .multiplo   (multiplo),
    .db_estado  (db_estado)
`ifdef CONDICIONADOR_CONTADOR_EN
    ,
    .db_num_jogadas (db_num_jogadas)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int         cyc;
    logic [8:0] code;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every jogada pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && jogada) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_jogada: got botoes_out=%0h expected no pulse (cycle %0d)", botoes_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("jogada_cycle", 32'(cyc), 32'(e.cyc));
        chk("jogada_code", 32'(botoes_out), 32'(e.code));
      end
    end
  end

  task automatic press(input logic [8:0] code, input bit accept);
    exp_t x;
    botoes_in = code;
    if (accept) begin
      x.cyc  = cyc + LAT;
      x.code = code;
      sb.push_back(x);
    end
    tick(LAT + 3);
  endtask

  task automatic release_chk(input logic [8:0] held, input logic mult);
    botoes_in = 9'h000;
    tick(D + 1);
    chk("release_held_out", 32'(botoes_out), 32'(held));
    chk("release_held_mult", 32'(multiplo), 32'(mult));
    tick(2);
    chk("release_out_zero", 32'(botoes_out), 0);
    chk("release_mult_zero", 32'(multiplo), 0);
    chk("release_state_idle", 32'(db_estado), 0);
    tick(3);
  endtask

  initial begin
    reset     = 1'b1;
    botoes_in = 9'h000;
    habilita  = 1'b1;
    tick(3);
    chk("rst_botoes_out", 32'(botoes_out), 0);
    chk("rst_jogada", 32'(jogada), 0);
    chk("rst_multiplo", 32'(multiplo), 0);
    chk("rst_estado", 32'(db_estado), 0);
    reset = 1'b0;
    tick(2);

    // Clean press and release
    press(9'h010, 1'b1);
    chk("clean_held", 32'(botoes_out), 32'h010);
    chk("clean_state", 32'(db_estado), 3);
    release_chk(9'h010, 1'b0);

    // Bounce: 2-cycle phases, last high phase continues as a steady hold
    for (int i = 0; i < 5; i++) begin
      botoes_in = (i % 2 == 0) ? 9'h001 : 9'h000;
      if (i < 4) tick(2);
    end
    begin
      exp_t x;
      x.cyc  = cyc + LAT;
      x.code = 9'h001;
      sb.push_back(x);
    end
    tick(LAT + 3);
    chk("bounce_held", 32'(botoes_out), 32'h001);
    release_chk(9'h001, 1'b0);

    // Multi-button press is rejected
    press(9'h011, 1'b0);
    chk("multi_mult", 32'(multiplo), 1);
    chk("multi_out", 32'(botoes_out), 0);
    chk("multi_state", 32'(db_estado), 4);
    botoes_in = 9'h111;  // extra buttons while held change nothing
    tick(3);
    chk("multi_extra_mult", 32'(multiplo), 1);
    botoes_in = 9'h011;
    release_chk(9'h000, 1'b1);

    // Disabled press ignored, then accepted once enabled
    habilita = 1'b0;
    press(9'h100, 1'b0);
    chk("dis_out", 32'(botoes_out), 0);
    chk("dis_state", 32'(db_estado), 3);
    habilita = 1'b1;
    tick(2);
    chk("dis_late_enable", 32'(botoes_out), 0);
    release_chk(9'h000, 1'b0);
    press(9'h100, 1'b1);
    habilita = 1'b0;  // no effect once accepted
    tick(2);
    chk("en_held", 32'(botoes_out), 32'h100);
    habilita = 1'b1;
    release_chk(9'h100, 1'b0);

    // Reset mid-hold, button stays pressed and is re-filtered
    press(9'h002, 1'b1);
    chk("mid_held", 32'(botoes_out), 32'h002);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_out", 32'(botoes_out), 0);
    chk("mid_rst_jog", 32'(jogada), 0);
    chk("mid_rst_mult", 32'(multiplo), 0);
    chk("mid_rst_state", 32'(db_estado), 0);
    reset = 1'b0;
    begin
      exp_t x;
      x.cyc  = cyc + LAT;
      x.code = 9'h002;
      sb.push_back(x);
    end
    tick(LAT + 3);
    chk("mid_reheld", 32'(botoes_out), 32'h002);
    release_chk(9'h002, 1'b0);

`ifdef CONDICIONADOR_CONTADOR_EN
    reset = 1'b1;
    tick(1);
    chk("cnt_rst", 32'(db_num_jogadas), 0);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 83; i++) begin
      logic [8:0] v;
      v = 9'(1 << (i % 9));
      press(v, 1'b1);
      if (i == 0)  chk("cnt_first", 32'(db_num_jogadas), 1);
      if (i == 80) chk("cnt_full", 32'(db_num_jogadas), 81);
      release_chk(v, 1'b0);
    end
    chk("cnt_saturated", 32'(db_num_jogadas), 81);
`endif

    tick(20);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
